// File: rtl/branch_pkg.sv
// ----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolution unit:
//   - BR_* : branch condition encodings carried on br_op
//   - state_t : FSM state encoding of branch_resolve_unit (2 bits)
// ----------------------------------------------------------------------------
package branch_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLE  = 3'b010;
    localparam logic [2:0] BR_BGT  = 3'b011;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LATCH  = 2'd1,
        S_DECIDE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// ----------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational branch condition evaluator.  Turns the registered
// comparison flags into a taken/not-taken decision for the selected op.
// Ports:
//   eq    in  1  operands equal
//   gt_s  in  1  first operand greater than second (signed)
//   gt_u  in  1  first operand greater than second (unsigned)
//   br_op in  3  condition select (BR_* encodings)
//   cond  out 1  branch condition holds
// ----------------------------------------------------------------------------
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic       eq,
    input  logic       gt_s,
    input  logic       gt_u,
    input  logic [2:0] br_op,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (br_op)
            BR_BEQ:  cond = eq;
            BR_BNE:  cond = !eq;
            BR_BLE:  cond = !gt_s;
            BR_BGT:  cond = gt_s;
            BR_BLT:  cond = !gt_s && !eq;
            BR_BGE:  cond = gt_s || eq;
            BR_BLTU: cond = !gt_u && !eq;
            BR_BGEU: cond = gt_u || eq;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
// Multicycle branch resolution: IDLE -> LATCH -> DECIDE -> DONE -> IDLE.
// A start seen in IDLE captures the operands; LATCH registers the compare
// flags, DECIDE registers taken/target, DONE pulses done for one cycle.
//
// Handshake: start is a request strobe that is only looked at in IDLE; it is
// accepted on the rising edge where start=1 and busy=0.  Exactly three cycles
// later done=1 for one cycle; taken/target are valid then and held until the
// next DECIDE.  Starts while busy are dropped, nothing is queued.
//
// Ports:
//   clk          in  1      rising-edge clock
//   reset        in  1      synchronous, active-high
//   start        in  1      request strobe (sampled in IDLE only)
//   br_op        in  3      condition select
//   rs_val       in  WIDTH  first operand
//   rt_val       in  WIDTH  second operand
//   pc_plus4     in  WIDTH  next sequential address
//   offset       in  16     signed word offset
//   busy         out 1      request in flight
//   done         out 1      one-cycle result-valid pulse
//   taken        out 1      branch decision
//   target       out WIDTH  branch target
//   taken_count  out CNT_W  saturating count of taken decisions
//   dbg_state    out 2      current FSM state (debug observation)
// ----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       br_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [15:0]      offset,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic [WIDTH-1:0] target,
    output logic [CNT_W-1:0] taken_count,
    output logic [1:0]       dbg_state
);

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_rs;
    logic [WIDTH-1:0] r_rt;
    logic [WIDTH-1:0] r_pc;
    logic [15:0]      r_off;
    logic [2:0]       r_op;
    logic             r_eq;
    logic             r_gt_s;
    logic             r_gt_u;
    logic             r_taken;
    logic [WIDTH-1:0] r_target;
    logic [CNT_W-1:0] r_cnt;

    logic             w_cond;
    logic [WIDTH-1:0] w_off_ext;
    logic [WIDTH-1:0] w_target;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_LATCH;
            S_LATCH:  w_next_state = S_DECIDE;
            S_DECIDE: w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Word offset sign-extended to WIDTH and scaled to bytes; the add wraps.
    assign w_off_ext = WIDTH'($signed(r_off)) << 2;
    assign w_target  = r_pc + w_off_ext;

    branch_cond_eval u_cond (
        .eq    (r_eq),
        .gt_s  (r_gt_s),
        .gt_u  (r_gt_u),
        .br_op (r_op),
        .cond  (w_cond)
    );

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs     <= '0;
            r_rt     <= '0;
            r_pc     <= '0;
            r_off    <= '0;
            r_op     <= '0;
            r_eq     <= 1'b0;
            r_gt_s   <= 1'b0;
            r_gt_u   <= 1'b0;
            r_taken  <= 1'b0;
            r_target <= '0;
            r_cnt    <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_rs  <= rs_val;
                r_rt  <= rt_val;
                r_pc  <= pc_plus4;
                r_off <= offset;
                r_op  <= br_op;
            end
            if (r_state == S_LATCH) begin
                r_eq   <= (r_rs == r_rt);
                r_gt_s <= ($signed(r_rs) > $signed(r_rt));
                r_gt_u <= (r_rs > r_rt);
            end
            if (r_state == S_DECIDE) begin
                r_taken  <= w_cond;
                r_target <= w_target;
                // Saturate rather than wrap at all-ones.
                if (w_cond && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign taken       = r_taken;
    assign target      = r_target;
    assign taken_count = r_cnt;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed table of branch requests with hand-computed results, followed by
// hand-written sequences: start held high, reset mid-flight and counter
// saturation (second instance with CNT_W=2 sharing the same inputs).
// ----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int WIDTH = 32;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pc;
        logic [15:0] off;
        logic        exp_taken;
        logic [31:0] exp_target;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [2:0]  br_op = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic [31:0] pc_plus4 = '0;
    logic [15:0] offset = '0;

    logic        busy, done, taken;
    logic [31:0] target;
    logic [15:0] taken_count;
    logic [1:0]  dbg_state;

    logic        busy2, done2, taken2;
    logic [31:0] target2;
    logic [1:0]  taken_count2;
    logic [1:0]  dbg_state2;

    branch_resolve_unit #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .br_op(br_op),
        .rs_val(rs_val), .rt_val(rt_val), .pc_plus4(pc_plus4), .offset(offset),
        .busy(busy), .done(done), .taken(taken), .target(target),
        .taken_count(taken_count), .dbg_state(dbg_state)
    );

    branch_resolve_unit #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .br_op(br_op),
        .rs_val(rs_val), .rt_val(rt_val), .pc_plus4(pc_plus4), .offset(offset),
        .busy(busy2), .done(done2), .taken(taken2), .target(target2),
        .taken_count(taken_count2), .dbg_state(dbg_state2)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_cnt  = '0;
    logic [1:0]  exp_cnt2 = '0;
    logic [WIDTH-1:0] exp_q[$];
    logic        exp_tk_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_taken();
        if (exp_cnt != 16'hFFFF) exp_cnt++;
        if (exp_cnt2 != 2'd3) exp_cnt2++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt  = '0;
        exp_cnt2 = '0;
    endtask

    // One request; inputs are scrambled while busy to prove they were captured.
    task automatic do_req(input string name, input logic [2:0] op,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] pc, input logic [15:0] off,
                          input logic exp_taken, input logic [31:0] exp_target);
        int lat;
        int busy_cyc;
        @(negedge clk);
        start = 1'b1; br_op = op; rs_val = rs; rt_val = rt; pc_plus4 = pc; offset = off;
        lat = 0;
        busy_cyc = 0;
        do begin
            @(negedge clk);
            start    = 1'b0;
            br_op    = 3'($urandom);
            rs_val   = $urandom;
            rt_val   = $urandom;
            pc_plus4 = $urandom;
            offset   = 16'($urandom);
            lat++;
            if (busy) busy_cyc++;
        end while (!done && lat < 8);
        if (exp_taken) model_taken();
        check({name, "_latency"}, 64'(lat), 64'd3);
        check({name, "_busy_cycles"}, 64'(busy_cyc), 64'd3);
        check({name, "_taken"}, 64'(taken), 64'(exp_taken));
        check({name, "_target"}, 64'(target), 64'(exp_target));
        check({name, "_count"}, 64'(taken_count), 64'(exp_cnt));
        check({name, "_count_sat"}, 64'(taken_count2), 64'(exp_cnt2));
        @(negedge clk);
        check({name, "_done_pulse_end"}, 64'({done, busy}), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[15];

    initial begin
        int          n_done;
        logic [31:0] t;
        logic        tk;

        vecs[0]  = '{3'b000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0100, 16'h0003, 1'b1, 32'h0000_010C};
        vecs[1]  = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_1000, 16'h0000, 1'b1, 32'h0000_1000};
        vecs[2]  = '{3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_1000, 16'h0000, 1'b0, 32'h0000_1000};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_1000, 16'h0000, 1'b0, 32'h0000_1000};
        vecs[4]  = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_1000, 16'h0000, 1'b1, 32'h0000_1000};
        vecs[5]  = '{3'b001, 32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 16'hFFFE, 1'b1, 32'hFFFF_FFFC};
        vecs[6]  = '{3'b010, 32'h0000_0003, 32'h0000_0003, 32'h0000_0200, 16'h7FFF, 1'b1, 32'h0002_01FC};
        vecs[7]  = '{3'b101, 32'hFFFF_FFFB, 32'h0000_0003, 32'h0000_0010, 16'h8000, 1'b0, 32'hFFFE_0010};
        vecs[8]  = '{3'b000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 16'h0001, 1'b0, 32'h0000_0004};
        vecs[9]  = '{3'b001, 32'h0000_0007, 32'h0000_0007, 32'hFFFF_FFFC, 16'h0001, 1'b0, 32'h0000_0000};
        vecs[10] = '{3'b011, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0040, 16'h0002, 1'b1, 32'h0000_0048};
        vecs[11] = '{3'b110, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 16'h0000, 1'b1, 32'h0000_0000};
        vecs[12] = '{3'b111, 32'h0000_0002, 32'h0000_0002, 32'h0000_0100, 16'h0010, 1'b1, 32'h0000_0140};
        vecs[13] = '{3'b100, 32'h0000_0002, 32'h0000_0002, 32'h0000_0000, 16'h0000, 1'b0, 32'h0000_0000};
        vecs[14] = '{3'b101, 32'h0000_0002, 32'h0000_0002, 32'h0000_0000, 16'h0000, 1'b1, 32'h0000_0000};

        // Reset state
        do_reset();
        @(negedge clk);
        check("reset_outputs", 64'({busy, done, taken}), 64'd0);
        check("reset_target", 64'(target), 64'd0);
        check("reset_count", 64'(taken_count), 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);

        // Table-driven requests
        for (int i = 0; i < 15; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].pc, vecs[i].off, vecs[i].exp_taken, vecs[i].exp_target);
        end

        // start held high; operands change every cycle. Accepts land on
        // loop edges 0, 4, 8 only (rs==rt only at those edges).
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check($sformatf("hold_done_c%0d", c), 64'(done),
                  64'((c == 3) || (c == 7) || (c == 11)));
            if (done) begin
                if (exp_q.size() > 0) begin
                    t  = exp_q.pop_front();
                    tk = exp_tk_q.pop_front();
                    check($sformatf("hold_target_c%0d", c), 64'(target), 64'(t));
                    check($sformatf("hold_taken_c%0d", c), 64'(taken), 64'(tk));
                end else begin
                    check("hold_unexpected_done", 64'd1, 64'd0);
                end
            end
            start    = (c <= 10);
            br_op    = 3'b000;
            rs_val   = 32'(c);
            rt_val   = (c % 4 == 0) ? 32'(c) : 32'(c + 1);
            pc_plus4 = 32'(c * 256);
            offset   = 16'h0000;
            if ((c % 4 == 0) && (c <= 8)) begin
                exp_q.push_back(32'(c * 256));
                exp_tk_q.push_back(1'b1);
                model_taken();
            end
        end
        start = 1'b0;
        check("hold_queue_empty", 64'(exp_q.size()), 64'd0);
        check("hold_count", 64'(taken_count), 64'(exp_cnt));

        // Reset asserted in DECIDE drops the request.
        @(negedge clk);
        start = 1'b1; br_op = 3'b000; rs_val = 32'd9; rt_val = 32'd9;
        pc_plus4 = 32'h500; offset = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        check("abort_state_latch", 64'(dbg_state), 64'd1);
        @(negedge clk);
        check("abort_state_decide", 64'(dbg_state), 64'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_cnt  = '0;
        exp_cnt2 = '0;
        check("abort_flags", 64'({busy, done, taken}), 64'd0);
        check("abort_target", 64'(target), 64'd0);
        check("abort_count", 64'(taken_count), 64'd0);
        check("abort_count_sat", 64'(taken_count2), 64'd0);
        check("abort_state", 64'(dbg_state), 64'd0);
        n_done = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        do_req("after_abort", 3'b000, 32'd9, 32'd9, 32'h500, 16'h0001, 1'b1, 32'h0000_0504);

        // Saturation on the CNT_W=2 instance: 1,2,3,3,3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_req($sformatf("sat%0d", i), 3'b000, 32'(i), 32'(i), 32'h0, 16'(i), 1'b1, 32'(i * 4));
        end
        check("sat_final", 64'(taken_count2), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
